// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a single-port memory with a
// fixed access latency; round-robin on ties, one transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WAIT   = 2
) (
  input  logic              clock,
  input  logic              n_reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              grant;
  logic              pick_dma;
  logic              any_req;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              last_access;

  assign any_req     = cpu_req | dma_req;
  assign last_access = (state == ACCESS) && (cnt == 4'd0);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    pick_dma = 1'b0;
    if (cpu_req && dma_req)
      pick_dma = (last_grant == GRANT_CPU);
    else
      pick_dma = dma_req;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= GRANT_DMA;
      grant      <= GRANT_CPU;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            cnt        <= CNT_LOAD;
            grant      <= pick_dma;
            last_grant <= pick_dma;
            lat_addr   <= pick_dma ? dma_addr  : cpu_addr;
            lat_wdata  <= pick_dma ? dma_wdata : cpu_wdata;
            lat_we     <= pick_dma ? dma_we    : cpu_we;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0)
            state <= DONE;
          else
            cnt <= cnt - 4'd1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data lands on the edge that closes the final access cycle.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (last_access && !lat_we) begin
      if (grant == GRANT_DMA)
        dma_rdata_q <= mem_rdata;
      else
        cpu_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && lat_we;
  assign mem_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign mem_wdata = (state == ACCESS) ? lat_wdata : '0;

  assign cpu_ack   = (state == DONE) && (grant == GRANT_CPU);
  assign dma_ack   = (state == DONE) && (grant == GRANT_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width of memory and requester addresses.
REQ-002 Parameter DATA_W, default 8, data width of memory and requester data.
REQ-003 Parameter WAIT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we  input  1 each  processor access request (level) and write qualifier.
REQ-007 cpu_addr  input  ADDR_W, cpu_wdata  input  DATA_W  processor address and write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to processor.
REQ-009 cpu_rdata  output  DATA_W  registered processor read data.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same directions/widths/meanings as cpu_* for the loader/DMA requester.
REQ-011 mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-012 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W  memory port.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, ACCESS, DONE; single shared memory port; one transaction at a time.
REQ-015 IDLE: no req -> stay IDLE; any req -> latch winner id, addr, we, wdata into internal registers, load counter with WAIT-1, go ACCESS.
REQ-016 Arbitration: only one req high -> that requester wins; both high -> requester other than last_grant wins (round-robin).
REQ-017 last_grant updates to the winner on the IDLE->ACCESS transition only.
REQ-018 ACCESS: mem_en=1, mem_addr/mem_wdata from latched values, mem_we=latched we; counter decrements each cycle; at counter==0 go DONE.
REQ-019 ACCESS lasts exactly WAIT cycles; on the final ACCESS cycle edge, a read captures mem_rdata into winner's rdata register.
REQ-020 DONE: winner's ack=1 for exactly one cycle, other ack=0, mem_en=mem_we=0; next state IDLE unconditionally.
REQ-021 Latency: req sampled high in IDLE cycle 0 -> ACCESS cycles 1..WAIT -> ack in cycle WAIT+1; minimum request-to-request period WAIT+2 cycles.
REQ-022 req still high in IDLE after ack is a new transaction (back-to-back allowed); requester drops req in DONE cycle to avoid it.
REQ-023 Requester inputs change or req deasserted during ACCESS/DONE: ignored; latched transaction completes and acks normally.
REQ-024 Outside ACCESS: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 cpu_rdata/dma_rdata change only on own read completion; writes and the other requester's reads leave them unchanged.
REQ-026 Counter width sufficient for WAIT (4 bits); no wrap-around in ACCESS.

Reset
REQ-027 n_reset low asynchronously forces IDLE, counter=0, last_grant=DMA (CPU wins first tie), all latched registers=0.
REQ-028 During reset: all outputs 0 (acks, mem_*, rdata, busy).
REQ-029 Reset mid-ACCESS aborts transaction with no ack; after release arbitration restarts from IDLE.

Verification
REQ-030 WAIT=2, cpu read addr 0x10, mem_rdata=0xA5 -> mem_en cycles 1-2, cpu_ack cycle 3, cpu_rdata=0xA5, dma_ack never.
REQ-031 After reset, cpu_req and dma_req high same cycle, held -> grants CPU, DMA, CPU, DMA; each ack 4 cycles apart.
REQ-032 dma write addr 0x3C data 0x5A -> mem_we=1 with mem_addr=0x3C, mem_wdata=0x5A for 2 cycles; dma_rdata unchanged; dma_ack once.
REQ-033 cpu_req high one cycle then low, cpu_addr changed in ACCESS -> original address held on mem_addr, cpu_ack still pulses cycle 3.
REQ-034 n_reset low during second ACCESS cycle -> mem_en, busy, acks 0 immediately; no ack; next request after release acks WAIT+1 cycles later.
REQ-035 WAIT=1 build, back-to-back cpu reads with req held -> acks every 3 cycles, busy low one cycle between.
